// File: rtl/video_pattern_gen.sv
// video_pattern_gen: synthesizable video stream source producing do/de/hs/vs
// framing with runtime geometry, pixel pacing, blanking and test pattern.
// Configuration is captured at every frame start; all outputs are registered.
module video_pattern_gen #(
   parameter int PIXEL_WIDTH     = 8,
   parameter int LINE_SIZE_MAX   = 4096,
   parameter int FRAME_CNT_WIDTH = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              en_i,
   input  logic [$clog2(LINE_SIZE_MAX):0]    cfg_width_i,
   input  logic [$clog2(LINE_SIZE_MAX):0]    cfg_height_i,
   input  logic [3:0]                        cfg_de_gap_i,
   input  logic [15:0]                       cfg_hblank_i,
   input  logic [15:0]                       cfg_vblank_i,
   input  logic [1:0]                        cfg_pattern_i,
   input  logic [7:0]                        cfg_step_i,
   input  logic [PIXEL_WIDTH-1:0]            cfg_const_i,
   output logic [PIXEL_WIDTH-1:0]            do_o,
   output logic                              de_o,
   output logic                              hs_o,
   output logic                              vs_o,
   output logic                              busy_o,
   output logic [FRAME_CNT_WIDTH-1:0]        frame_cnt_o
);

   localparam int CW = $clog2(LINE_SIZE_MAX) + 1;

   typedef enum logic [2:0] {
      IDLE,
      VBLANK,
      GAP,
      PIX,
      HBLANK
   } state_t;

   state_t                      state_q, state_d;
   logic [15:0]                 cnt_q, cnt_d;
   logic [CW-1:0]               x_q, x_d, y_q, y_d;
   logic [7:0]                  gx_q, gx_d, gy_q, gy_d;

   logic [CW-1:0]               w_q, w_d, h_q, h_d;
   logic [3:0]                  gap_q, gap_d;
   logic [15:0]                 hb_q, hb_d;
   logic [7:0]                  step_q, step_d;
   logic [1:0]                  pat_q, pat_d;
   logic [PIXEL_WIDTH-1:0]      const_q, const_d;

   logic [PIXEL_WIDTH-1:0]      do_q, do_d;
   logic                        de_q, de_d, hs_q, hs_d, vs_q, vs_d, busy_q, busy_d;
   logic [FRAME_CNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d;

   logic                        latch, start_pix, frame_done;

   // Next-state logic: frame sequencing, pixel/line counters and config capture.
   // start_pix and latch collect the shared "enter GAP/PIX" and "enter VBLANK"
   // actions so each is described once.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      x_d        = x_q;
      y_d        = y_q;
      gx_d       = gx_q;
      gy_d       = gy_q;
      w_d        = w_q;
      h_d        = h_q;
      gap_d      = gap_q;
      hb_d       = hb_q;
      step_d     = step_q;
      pat_d      = pat_q;
      const_d    = const_q;
      latch      = 1'b0;
      start_pix  = 1'b0;
      frame_done = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (en_i) latch = 1'b1;
         end
         VBLANK: begin
            if (cnt_q == '0) begin
               x_d       = '0;
               y_d       = '0;
               gx_d      = '0;
               gy_d      = '0;
               start_pix = 1'b1;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         GAP: begin
            if (cnt_q == '0) state_d = PIX;
            else             cnt_d   = cnt_q - 16'd1;
         end
         PIX: begin
            if (x_q < w_q - CW'(1)) begin
               x_d       = x_q + CW'(1);
               gx_d      = (gx_q == step_q - 8'd1) ? '0 : gx_q + 8'd1;
               start_pix = 1'b1;
            end else if (y_q < h_q - CW'(1)) begin
               state_d = HBLANK;
               cnt_d   = hb_q - 16'd1;
            end else begin
               frame_done = 1'b1;
               if (en_i) latch   = 1'b1;
               else      state_d = IDLE;
            end
         end
         HBLANK: begin
            if (cnt_q == '0) begin
               y_d       = y_q + CW'(1);
               x_d       = '0;
               gx_d      = '0;
               gy_d      = (gy_q == step_q - 8'd1) ? '0 : gy_q + 8'd1;
               start_pix = 1'b1;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (start_pix) begin
         if (gap_q != '0) begin
            state_d = GAP;
            cnt_d   = {12'd0, gap_q} - 16'd1;
         end else begin
            state_d = PIX;
         end
      end

      // Zero-valued sizes and blanking lengths are substituted by 1 on capture.
      if (latch) begin
         state_d = VBLANK;
         cnt_d   = (cfg_vblank_i == '0) ? 16'd0 : cfg_vblank_i - 16'd1;
         w_d     = (cfg_width_i  == '0) ? CW'(1) : cfg_width_i;
         h_d     = (cfg_height_i == '0) ? CW'(1) : cfg_height_i;
         gap_d   = cfg_de_gap_i;
         hb_d    = (cfg_hblank_i == '0) ? 16'd1 : cfg_hblank_i;
         step_d  = (cfg_step_i   == '0) ? 8'd1  : cfg_step_i;
         pat_d   = cfg_pattern_i;
         const_d = cfg_const_i;
      end
   end

   // Output decode from the next state so the registered outputs line up with state_q.
   always_comb begin
      de_d        = (state_d == PIX);
      hs_d        = (state_d == IDLE) || (state_d == VBLANK) || (state_d == HBLANK);
      vs_d        = (state_d == IDLE) || (state_d == VBLANK);
      busy_d      = (state_d != IDLE);
      do_d        = do_q;
      frame_cnt_d = frame_cnt_q;
      if (state_d == PIX) begin
         unique case (pat_q)
            2'd0:    do_d = PIXEL_WIDTH'(x_d);
            2'd1:    do_d = PIXEL_WIDTH'(y_d);
            2'd2:    do_d = ((gx_d == '0) && (gy_d == '0)) ? '1 : '0;
            default: do_d = const_q;
         endcase
      end
      if (frame_done) frame_cnt_d = frame_cnt_q + FRAME_CNT_WIDTH'(1);
   end

   // State, counter, captured-config and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         x_q         <= '0;
         y_q         <= '0;
         gx_q        <= '0;
         gy_q        <= '0;
         w_q         <= CW'(1);
         h_q         <= CW'(1);
         gap_q       <= '0;
         hb_q        <= 16'd1;
         step_q      <= 8'd1;
         pat_q       <= '0;
         const_q     <= '0;
         do_q        <= '0;
         de_q        <= 1'b0;
         hs_q        <= 1'b1;
         vs_q        <= 1'b1;
         busy_q      <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         x_q         <= x_d;
         y_q         <= y_d;
         gx_q        <= gx_d;
         gy_q        <= gy_d;
         w_q         <= w_d;
         h_q         <= h_d;
         gap_q       <= gap_d;
         hb_q        <= hb_d;
         step_q      <= step_d;
         pat_q       <= pat_d;
         const_q     <= const_d;
         do_q        <= do_d;
         de_q        <= de_d;
         hs_q        <= hs_d;
         vs_q        <= vs_d;
         busy_q      <= busy_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign do_o        = do_q;
   assign de_o        = de_q;
   assign hs_o        = hs_q;
   assign vs_o        = vs_q;
   assign busy_o      = busy_q;
   assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: expected per-cycle streams are built from the
// frame geometry (vblank, gaps, pixels, hblank) and compared cycle by cycle.
module tb_video_pattern_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic [12:0] c_width = 13'd4, c_height = 13'd2;
   logic [3:0]  c_gap = 4'd0;
   logic [15:0] c_hblank = 16'd3, c_vblank = 16'd2;
   logic [1:0]  c_pattern = 2'd0;
   logic [7:0]  c_step = 8'd1, c_const = 8'h00;

   logic [7:0]  do_o;
   logic        de_o, hs_o, vs_o, busy_o;
   logic [15:0] frame_cnt_o;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic [15:0] fc_exp   = 16'd0;
   int          ff_cnt;

   // ctl = {busy, vs, hs, de}
   typedef struct {
      logic [3:0]  ctl;
      int unsigned dat;
   } exp_t;
   exp_t exp_q[$];

   localparam logic [3:0] C_IDLE = 4'b0110;
   localparam logic [3:0] C_VBL  = 4'b1110;
   localparam logic [3:0] C_HBL  = 4'b1010;
   localparam logic [3:0] C_GAP  = 4'b1000;
   localparam logic [3:0] C_PIX  = 4'b1001;

   video_pattern_gen #(
      .PIXEL_WIDTH     (8),
      .LINE_SIZE_MAX   (4096),
      .FRAME_CNT_WIDTH (16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .en_i          (en),
      .cfg_width_i   (c_width),
      .cfg_height_i  (c_height),
      .cfg_de_gap_i  (c_gap),
      .cfg_hblank_i  (c_hblank),
      .cfg_vblank_i  (c_vblank),
      .cfg_pattern_i (c_pattern),
      .cfg_step_i    (c_step),
      .cfg_const_i   (c_const),
      .do_o          (do_o),
      .de_o          (de_o),
      .hs_o          (hs_o),
      .vs_o          (vs_o),
      .busy_o        (busy_o),
      .frame_cnt_o   (frame_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference frame: vblank, then per line (hblank between lines) gap+pixel groups.
   task automatic build_frame();
      int w, h, hb, vb, st, g, v;
      exp_q.delete();
      w  = (c_width  == 0) ? 1 : int'(c_width);
      h  = (c_height == 0) ? 1 : int'(c_height);
      hb = (c_hblank == 0) ? 1 : int'(c_hblank);
      vb = (c_vblank == 0) ? 1 : int'(c_vblank);
      st = (c_step   == 0) ? 1 : int'(c_step);
      g  = int'(c_gap);
      for (int i = 0; i < vb; i++) exp_q.push_back('{C_VBL, 0});
      for (int y = 0; y < h; y++) begin
         if (y > 0) for (int i = 0; i < hb; i++) exp_q.push_back('{C_HBL, 0});
         for (int x = 0; x < w; x++) begin
            for (int i = 0; i < g; i++) exp_q.push_back('{C_GAP, 0});
            case (c_pattern)
               2'd0:    v = x % 256;
               2'd1:    v = y % 256;
               2'd2:    v = ((x % st == 0) && (y % st == 0)) ? 255 : 0;
               default: v = int'(c_const);
            endcase
            exp_q.push_back('{C_PIX, v});
         end
      end
   endtask

   // Play one frame starting at the edge that captures the config.
   task automatic play_frame(input int drop_at, input int chg_at, input int new_w, input int rst_pix);
      int npix;
      exp_t e;
      npix   = 0;
      ff_cnt = 0;
      build_frame();
      for (int i = 0; i < exp_q.size(); i++) begin
         e = exp_q[i];
         @(posedge clk); #1;
         check("ctl", 32'({busy_o, vs_o, hs_o, de_o}), 32'(e.ctl));
         check("fcnt", 32'(frame_cnt_o), 32'(fc_exp));
         if (e.ctl[0]) begin
            check("do", 32'(do_o), e.dat);
            if (do_o == 8'hFF) ff_cnt++;
            npix++;
         end
         if (i == drop_at) en = 1'b0;
         if (i == chg_at)  c_width = 13'(new_w);
         if (e.ctl[0] && npix == rst_pix) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            fc_exp = 16'd0;
            check("rst_ctl", 32'({busy_o, vs_o, hs_o, de_o}), 32'(C_IDLE));
            check("rst_fcnt", 32'(frame_cnt_o), 32'd0);
            check("rst_do", 32'(do_o), 32'd0);
            return;
         end
      end
      fc_exp++;
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset_ctl", 32'({busy_o, vs_o, hs_o, de_o}), 32'(C_IDLE));
      check("reset_fcnt", 32'(frame_cnt_o), 32'd0);
      check("reset_do", 32'(do_o), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("idle_hold", 32'({busy_o, vs_o, hs_o, de_o}), 32'(C_IDLE));

      // Basic timing: 4x2, no gap, hblank 3, vblank 2, x ramp
      c_width = 13'd4; c_height = 13'd2; c_gap = 4'd0; c_hblank = 16'd3;
      c_vblank = 16'd2; c_pattern = 2'd0; en = 1'b1;
      play_frame(-1, -1, 0, -1);

      // Pixel pacing: de every other cycle, 5 pixels per line
      c_gap = 4'd1; c_width = 13'd5; c_height = 13'd2; c_hblank = 16'd2; c_vblank = 16'd1;
      play_frame(-1, -1, 0, -1);

      // Delta grid 25x25 pitch 5
      c_width = 13'd25; c_height = 13'd25; c_step = 8'd5; c_pattern = 2'd2;
      c_gap = 4'd1; c_hblank = 16'd2; c_vblank = 16'd2;
      play_frame(-1, -1, 0, -1);
      check("grid_ones", 32'(ff_cnt), 32'd25);

      // Config latching: width changed mid-frame applies to the next frame only
      c_width = 13'd4; c_height = 13'd3; c_pattern = 2'd0; c_gap = 4'd0;
      c_hblank = 16'd1; c_vblank = 16'd1;
      play_frame(-1, 5, 6, -1);
      play_frame(-1, -1, 0, -1);

      // Zero substitution
      c_width = 13'd0; c_height = 13'd2; c_hblank = 16'd0; c_vblank = 16'd0;
      c_pattern = 2'd1;
      play_frame(-1, -1, 0, -1);

      // Randomised frames
      for (int k = 0; k < 8; k++) begin
         c_width   = 13'($urandom_range(0, 20));
         c_height  = 13'($urandom_range(0, 6));
         c_gap     = 4'($urandom_range(0, 3));
         c_hblank  = 16'($urandom_range(0, 5));
         c_vblank  = 16'($urandom_range(0, 5));
         c_pattern = 2'($urandom_range(0, 3));
         c_step    = 8'($urandom_range(0, 4));
         c_const   = 8'($urandom);
         play_frame(-1, -1, 0, -1);
      end

      // Reset mid-line, then a full restart with vblank
      c_width = 13'd4; c_height = 13'd3; c_gap = 4'd0; c_hblank = 16'd2;
      c_vblank = 16'd3; c_pattern = 2'd3; c_const = 8'h5A;
      play_frame(-1, -1, 0, 6);
      play_frame(-1, -1, 0, -1);

      // Stop after frame: en dropped in line 1 of a 4x3 frame
      c_width = 13'd4; c_height = 13'd3; c_hblank = 16'd2; c_vblank = 16'd1;
      c_pattern = 2'd0;
      play_frame(8, -1, 0, -1);
      @(posedge clk); #1;
      check("stop_ctl", 32'({busy_o, vs_o, hs_o, de_o}), 32'(C_IDLE));
      check("stop_fcnt", 32'(frame_cnt_o), 32'(fc_exp));
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("stop_idle", 32'({busy_o, vs_o, hs_o, de_o}), 32'(C_IDLE));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
